mux4_rr_arbiter: RTL

//  Round-robin arbiter that shares a 4:1 multiplexer between four requesters A..D.

---
 rtl/mux4_arb_pkg.sv | 35 +++
 rtl/mux4_w.sv | 22 ++
 rtl/mux4_rr_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types, select constants and round-robin helpers for the 4:1 mux arbiter.
package mux4_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  // Returns {found, idx}: first set request scanning upward from ptr, modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + i[1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_w.sv
// W-wide combinational 4:1 mux, selected on S0 first and then on S1.
module mux4_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [1:0]   s,
  output logic [W-1:0] f
);

  logic [W-1:0] lo;
  logic [W-1:0] hi;

  always_comb begin
    lo = s[0] ? b : a;
    hi = s[0] ? d : c;
    f  = s[1] ? hi : lo;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux among requesters A..D, with a bounded
// grant length and a registered output channel.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     grant,
  output logic [1:0]     sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic [1:0]     out_src
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t        state, state_d;
  logic [3:0]    grant_d;
  logic [1:0]    sel_d;
  logic [W-1:0]  out_data_d;
  logic          out_valid_d;
  logic [1:0]    out_src_d;
  logic [1:0]    rr_ptr, rr_ptr_d;
  logic [HW-1:0] hold_cnt, hold_d;

  logic [W-1:0]  mux_f;
  logic [2:0]    pick_ptr;
  logic [2:0]    pick_next;
  logic [1:0]    sel_next;
  logic          beat;
  logic          others;

  mux4_w #(.W(W)) u_mux (
    .a (in_data[W-1:0]),
    .b (in_data[2*W-1:W]),
    .c (in_data[3*W-1:2*W]),
    .d (in_data[4*W-1:3*W]),
    .s (sel),
    .f (mux_f)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      sel       <= SEL_A;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_src   <= SEL_A;
      rr_ptr    <= SEL_A;
      hold_cnt  <= '0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      sel       <= sel_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_src   <= out_src_d;
      rr_ptr    <= rr_ptr_d;
      hold_cnt  <= hold_d;
    end
  end

  always_comb begin
    state_d     = state;
    grant_d     = grant;
    sel_d       = sel;
    out_data_d  = out_data;
    out_valid_d = 1'b0;
    out_src_d   = out_src;
    rr_ptr_d    = rr_ptr;
    hold_d      = hold_cnt;

    sel_next  = sel + 2'd1;
    pick_ptr  = rr_pick(req, rr_ptr);
    // Scanning from sel+1 reaches every other requester before sel itself.
    pick_next = rr_pick(req, sel_next);
    beat      = req[sel];
    others    = |(req & ~onehot(sel));

    case (state)
      ST_IDLE: begin
        if (pick_ptr[2]) begin
          state_d = ST_GRANT;
          grant_d = onehot(pick_ptr[1:0]);
          sel_d   = pick_ptr[1:0];
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (beat) begin
          out_valid_d = 1'b1;
          out_data_d  = mux_f;
          out_src_d   = sel;
          if (hold_cnt == HOLD_LAST) begin
            hold_d = '0;
            if (others) begin
              grant_d  = onehot(pick_next[1:0]);
              sel_d    = pick_next[1:0];
              rr_ptr_d = sel_next;
            end
          end else begin
            hold_d = hold_cnt + HW'(1);
          end
        end else begin
          rr_ptr_d = sel_next;
          hold_d   = '0;
          if (pick_next[2]) begin
            grant_d = onehot(pick_next[1:0]);
            sel_d   = pick_next[1:0];
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

endmodule
